// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration bus between the AHB masters and the bridge arbiter.
// The master modport is the environment side, slave is the arbiter.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] Hbusreq;
  logic [NUM_MASTERS-1:0] Hlock;
  logic [1:0]             Htrans;
  logic                   Hready;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [MW-1:0]          Hmaster;
  logic [MW-1:0]          Hmaster_data;
  logic                   Hmastlock;

  modport master (
    output Hbusreq, Hlock, Htrans, Hready,
    input  Hgrant, Hmaster, Hmaster_data, Hmastlock
  );

  modport slave (
    input  Hbusreq, Hlock, Htrans, Hready,
    output Hgrant, Hmaster, Hmaster_data, Hmastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with beat-count fairness and lock exemption.
// Ownership only changes on Hready-high edges; all outputs are registered.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS      = 8
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  ahb_bus_arbiter_if.slave   bus
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [MW-1:0]          DEF     = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [CW:0]            MAXC    = (CW+1)'(MAX_BEATS);

  typedef enum logic {ST_PARK, ST_OWN} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          master_q, master_d, mdata_q;
  logic [MW-1:0]          rr_last_q, rr_last_d, win;
  logic                   mastlock_q, mastlock_d;
  logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
  logic                   beat, owner_req, owner_lock, others, take, park;
  logic [CW:0]            cnt_sum, cnt_sat;

  // Descending scan so the closest index after rr_last wins; rr_last itself is last.
  always_comb begin
    win = rr_last_q;
    for (int k = NUM_MASTERS; k >= 1; k--)
      if (bus.Hbusreq[(int'(rr_last_q) + k) % NUM_MASTERS])
        win = MW'((int'(rr_last_q) + k) % NUM_MASTERS);
  end

  assign beat       = bus.Hready & bus.Htrans[1];
  assign owner_req  = |(bus.Hbusreq & grant_q);
  assign owner_lock = |(bus.Hlock & grant_q);
  assign others     = |(bus.Hbusreq & ~grant_q);
  assign cnt_sum    = {1'b0, beat_cnt_q} + {{CW{1'b0}}, beat};
  assign cnt_sat    = (cnt_sum >= MAXC) ? MAXC : cnt_sum;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    master_d   = master_q;
    rr_last_d  = rr_last_q;
    mastlock_d = mastlock_q;
    beat_cnt_d = beat_cnt_q;
    take       = 1'b0;
    park       = 1'b0;
    case (state_q)
      ST_PARK: take = |bus.Hbusreq;
      ST_OWN: begin
        // Release takes priority over preemption when both land on one edge.
        if (!owner_req) begin
          take = others;
          park = ~others;
        end else if (owner_lock) begin
          beat_cnt_d = CW'(cnt_sat);
          mastlock_d = 1'b1;
        end else if (cnt_sum >= MAXC && others) begin
          take = 1'b1;
        end else begin
          beat_cnt_d = CW'(cnt_sat);
          mastlock_d = 1'b0;
        end
      end
      default: park = 1'b1;
    endcase
    if (take) begin
      state_d    = ST_OWN;
      grant_d    = NUM_MASTERS'(1) << win;
      master_d   = win;
      rr_last_d  = win;
      mastlock_d = bus.Hlock[win];
      beat_cnt_d = '0;
    end
    if (park) begin
      state_d    = ST_PARK;
      grant_d    = DEF_GNT;
      master_d   = DEF;
      mastlock_d = 1'b0;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q    <= ST_PARK;
      grant_q    <= DEF_GNT;
      master_q   <= DEF;
      mdata_q    <= DEF;
      rr_last_q  <= DEF;
      mastlock_q <= 1'b0;
      beat_cnt_q <= '0;
    end else if (bus.Hready) begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      master_q   <= master_d;
      mdata_q    <= master_q;
      rr_last_q  <= rr_last_d;
      mastlock_q <= mastlock_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.Hgrant       = grant_q;
  assign bus.Hmaster      = master_q;
  assign bus.Hmaster_data = mdata_q;
  assign bus.Hmastlock    = mastlock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios plus random traffic.
module tb_ahb_bus_arbiter;
  localparam int N    = 4;
  localparam int DEF  = 0;
  localparam int MAXB = 8;
  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  logic Hclk = 1'b0;
  logic Hresetn = 1'b0;
  always #5 Hclk = ~Hclk;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();
  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .MAX_BEATS(MAXB)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .bus(bus)
  );

  typedef struct {
    int grant;
    int master;
    int mdata;
    int lock;
    int cnt;
  } exp_t;

  exp_t  sbq[$];
  int    n_chk = 0, n_pass = 0;
  string phase = "init";

  int m_state, m_master, m_mdata, m_lock, m_cnt, m_rr;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s/%s got=%0d exp=%0d", phase, tag, got, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_master = DEF; m_mdata = DEF; m_lock = 0; m_cnt = 0; m_rr = DEF;
    sbq.delete();
  endtask

  task automatic model_edge(input logic [N-1:0] req, lck, input logic [1:0] tr, input logic rdy);
    int w, beat, nsum;
    bit others;
    if (!rdy) return;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
    beat = tr[1] ? 1 : 0;
    nsum = (m_cnt + beat > MAXB) ? MAXB : m_cnt + beat;
    m_mdata = m_master;
    others = (req & ~(4'b0001 << m_master)) != 0;
    if (m_state == 0) begin
      if (w >= 0) begin m_state = 1; m_master = w; m_rr = w; m_cnt = 0; m_lock = lck[w]; end
    end else if (!req[m_master] && !others) begin
      m_state = 0; m_master = DEF; m_cnt = 0; m_lock = 0;
    end else if (!req[m_master] || (!lck[m_master] && m_cnt + beat >= MAXB && others)) begin
      m_master = w; m_rr = w; m_cnt = 0; m_lock = lck[w];
    end else begin
      m_cnt = nsum; m_lock = lck[m_master];
    end
  endtask

  // Drive one cycle, queue the model's prediction, compare after the edge.
  task automatic step(input logic [N-1:0] req, lck, input logic [1:0] tr, input logic rdy);
    exp_t e;
    @(negedge Hclk);
    bus.Hbusreq = req; bus.Hlock = lck; bus.Htrans = tr; bus.Hready = rdy;
    model_edge(req, lck, tr, rdy);
    sbq.push_back('{(m_state == 0) ? (1 << DEF) : (1 << m_master), m_master, m_mdata, m_lock, m_cnt});
    @(posedge Hclk);
    #1;
    e = sbq.pop_front();
    chk("grant", int'(bus.Hgrant), e.grant);
    chk("master", int'(bus.Hmaster), e.master);
    chk("mdata", int'(bus.Hmaster_data), e.mdata);
    chk("mlock", int'(bus.Hmastlock), e.lock);
    chk("beatcnt", int'(dut.beat_cnt_q), e.cnt);
  endtask

  task automatic chk_reset_vals();
    chk("rst_grant", int'(bus.Hgrant), 1 << DEF);
    chk("rst_master", int'(bus.Hmaster), DEF);
    chk("rst_mdata", int'(bus.Hmaster_data), DEF);
    chk("rst_mlock", int'(bus.Hmastlock), 0);
    chk("rst_cnt", int'(dut.beat_cnt_q), 0);
    chk("rst_state", int'(dut.state_q), 0);
  endtask

  // Asynchronous assert away from the clock edge; release on a negedge with quiet inputs.
  task automatic do_reset();
    #2;
    Hresetn = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    bus.Hbusreq = '0; bus.Hlock = '0; bus.Htrans = IDLE; bus.Hready = 1'b1;
    @(negedge Hclk);
    Hresetn = 1'b1;
  endtask

  initial begin
    int order[5];
    int exp_order[5];
    int sw;
    logic [N-1:0] r, l;
    bus.Hbusreq = '0; bus.Hlock = '0; bus.Htrans = IDLE; bus.Hready = 1'b1;
    model_reset();
    #12;
    phase = "reset";
    chk_reset_vals();
    @(negedge Hclk);
    Hresetn = 1'b1;

    phase = "idle";
    for (int i = 0; i < 5; i++) step('0, '0, IDLE, 1'b1);
    chk("idle_state", int'(dut.state_q), 0);

    phase = "rst_mid";
    step(4'b0100, '0, NSEQ, 1'b1);
    chk("grant2", int'(bus.Hgrant), 4'b0100);
    do_reset();

    phase = "rr";
    step(4'b1000, '0, NSEQ, 1'b1);
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111 & ~(4'b0001 << m_master), '0, NSEQ, 1'b1);
      order[i] = int'(bus.Hmaster);
    end
    for (int i = 0; i < 5; i++) chk("rr_order", order[i], exp_order[i]);

    phase = "fair";
    step('0, '0, IDLE, 1'b1);
    step(4'b0010, '0, NSEQ, 1'b1);
    sw = -1;
    for (int b = 1; b <= 10; b++) begin
      step((b >= 3) ? 4'b1010 : 4'b0010, '0, SEQ, 1'b1);
      if (sw < 0 && bus.Hgrant == 4'b1000) begin
        sw = b;
        chk("cnt_after_sw", int'(dut.beat_cnt_q), 0);
      end
    end
    chk("preempt_beat", sw, MAXB);

    phase = "lock";
    step('0, '0, IDLE, 1'b1);
    step(4'b0100, 4'b0100, NSEQ, 1'b1);
    for (int b = 0; b < 12; b++) begin
      step(4'b0101, 4'b0100, SEQ, 1'b1);
      chk("lock_grant", int'(bus.Hgrant), 4'b0100);
      chk("lock_mlock", int'(bus.Hmastlock), 1);
    end
    step(4'b0001, '0, NSEQ, 1'b1);
    chk("unlock_grant", int'(bus.Hgrant), 4'b0001);

    phase = "wait";
    step('0, '0, IDLE, 1'b1);
    step(4'b0001, '0, NSEQ, 1'b1);
    for (int b = 0; b < 7; b++) step(4'b0001, '0, NSEQ, 1'b1);
    chk("cnt7", int'(dut.beat_cnt_q), 7);
    for (int b = 0; b < 4; b++) begin
      step(4'b0011, '0, NSEQ, 1'b0);
      chk("ws_grant", int'(bus.Hgrant), 4'b0001);
      chk("ws_cnt", int'(dut.beat_cnt_q), 7);
    end
    step(4'b0011, '0, NSEQ, 1'b1);
    chk("ws_switch", int'(bus.Hgrant), 4'b0010);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom);
      l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step(r, l, 2'($urandom), ($urandom_range(0, 3) != 0));
      if (i == 200) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
